odd_pipe: RTL and testbench



---
 rtl/descriptions.sv | 43 ++++
 rtl/odd_permute.sv | 23 ++
 rtl/odd_pipe.sv | 146 ++++++++++++++
 tb/tb_odd_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/descriptions.sv
// Shared odd/even pipe opcode encoding, quadword type, address masks and immediate helpers.
package descriptions;

  typedef logic [0:127] quadword_t;

  typedef enum logic [6:0] {
    NO_OPERATION_LOAD                      = 7'h00,
    SHIFT_LEFT_QUADWORD_BY_BITS            = 7'h01,
    SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE  = 7'h02,
    SHIFT_LEFT_QUADWORD_BY_BYTES           = 7'h03,
    SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE = 7'h04,
    ROTATE_QUADWORD_BY_BYTES               = 7'h05,
    ROTATE_QUADWORD_BY_BYTES_IMMEDIATE     = 7'h06,
    ROTATE_QUADWORD_BY_BITS                = 7'h07,
    ROTATE_QUADWORD_BY_BITS_IMMEDIATE      = 7'h08,
    LOAD_QUADWORD_D                        = 7'h09,
    LOAD_QUADWORD_X                        = 7'h0A,
    LOAD_QUADWORD_A                        = 7'h0B,
    STORE_QUADWORD_D                       = 7'h0C,
    STORE_QUADWORD_X                       = 7'h0D,
    STORE_QUADWORD_A                       = 7'h0E,
    BRANCH_RELATIVE                        = 7'h0F,
    BRANCH_ABSOLUTE                        = 7'h10,
    BRANCH_RELATIVE_AND_SET_LINK           = 7'h11,
    BRANCH_INDIRECT                        = 7'h12,
    BRANCH_IF_NOT_ZERO_WORD                = 7'h13,
    BRANCH_IF_ZERO_WORD                    = 7'h14,
    ADD_WORD                               = 7'h40,
    AND_WORD                               = 7'h41
  } opcode;

  localparam logic [14:0] LS_ADDR_MASK = 15'h7FF0;
  localparam logic [31:0] PC_MASK      = 32'h0000_7FFC;

  function automatic logic [31:0] sext_i10_x16(input logic [0:9] imm);
    return {{18{imm[0]}}, imm, 4'b0000};
  endfunction

  function automatic logic [31:0] sext_i16_x4(input logic [0:15] imm);
    return {{14{imm[0]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/odd_permute.sv
// Combinational quadword shift-left / rotate-left unit; count is in bits or bytes.
// Byte shifts by 16 or more fall off the top and yield zero.
module odd_permute
  import descriptions::*;
(
  input  quadword_t  ra_in,
  input  logic [4:0] count_in,
  input  logic       bytes_in,
  input  logic       rotate_in,
  output quadword_t  result_out
);

  logic [7:0] amt;

  always_comb begin
    amt = bytes_in ? {count_in, 3'b000} : {5'b00000, count_in[2:0]};
    if (rotate_in)
      result_out = (ra_in << amt) | (ra_in >> (8'd128 - amt));
    else
      result_out = ra_in << amt;
  end

endmodule

// File: rtl/odd_pipe.sv
// Odd execution pipe: permute, local-store load/store and branch; 1-cycle registered writeback/PC.
// LS port is combinational with the sampled instruction; no stalls, no handshake.
module odd_pipe
  import descriptions::*;
(
  input  logic        clock,
  input  logic        reset,
  input  opcode       op_input_op_code,
  input  logic [0:6]  I7_input,
  input  logic [0:9]  I10_input,
  input  logic [0:15] I16_input,
  input  logic [0:17] I18_input,
  input  quadword_t   ra_input,
  input  quadword_t   rb_input,
  input  quadword_t   rc_input,
  input  logic [6:0]  rt_address_input,
  input  logic [31:0] PC_input,
  output logic [31:0] PC_output,
  output quadword_t   rt_value_output,
  output logic [6:0]  rt_address_output,
  output logic        wrt_en_output,
  output logic [0:14] LS_address_output,
  input  quadword_t   LS_data_input,
  output quadword_t   LS_data_output,
  output logic        LS_wrt_en
);

  logic [4:0]  perm_count;
  logic        perm_bytes, perm_rotate;
  quadword_t   perm_result;

  logic [31:0] pc_d, pc_q;
  quadword_t   rt_value_d, rt_value_q;
  logic [6:0]  rt_address_d, rt_address_q;
  logic        wrt_en_d, wrt_en_q;

  logic [31:0] ls_ea, rel_target;
  logic        ls_access, ls_store;
  logic        unused_bits;

  assign unused_bits = ^{I18_input, I7_input[0:1], rb_input[32:127], ls_ea[31:15]};

  always_comb begin
    perm_count  = 5'd0;
    perm_bytes  = 1'b0;
    perm_rotate = 1'b0;
    case (op_input_op_code)
      SHIFT_LEFT_QUADWORD_BY_BITS:            perm_count = {2'b00, rb_input[29:31]};
      SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE:  perm_count = {2'b00, I7_input[4:6]};
      SHIFT_LEFT_QUADWORD_BY_BYTES:           begin perm_count = rb_input[27:31]; perm_bytes = 1'b1; end
      SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE: begin perm_count = I7_input[2:6]; perm_bytes = 1'b1; end
      ROTATE_QUADWORD_BY_BYTES:
        begin perm_count = {1'b0, rb_input[28:31]}; perm_bytes = 1'b1; perm_rotate = 1'b1; end
      ROTATE_QUADWORD_BY_BYTES_IMMEDIATE:
        begin perm_count = {1'b0, I7_input[3:6]}; perm_bytes = 1'b1; perm_rotate = 1'b1; end
      ROTATE_QUADWORD_BY_BITS:           begin perm_count = {2'b00, rb_input[29:31]}; perm_rotate = 1'b1; end
      ROTATE_QUADWORD_BY_BITS_IMMEDIATE: begin perm_count = {2'b00, I7_input[4:6]}; perm_rotate = 1'b1; end
      default: ;
    endcase
  end

  odd_permute u_permute (
    .ra_in      (ra_input),
    .count_in   (perm_count),
    .bytes_in   (perm_bytes),
    .rotate_in  (perm_rotate),
    .result_out (perm_result)
  );

  always_comb begin
    pc_d         = PC_input + 32'd4;
    rt_value_d   = '0;
    rt_address_d = rt_address_input;
    wrt_en_d     = 1'b0;
    ls_ea        = 32'd0;
    ls_access    = 1'b0;
    ls_store     = 1'b0;
    rel_target   = (PC_input + sext_i16_x4(I16_input)) & PC_MASK;
    case (op_input_op_code)
      SHIFT_LEFT_QUADWORD_BY_BITS, SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE,
      SHIFT_LEFT_QUADWORD_BY_BYTES, SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE,
      ROTATE_QUADWORD_BY_BYTES, ROTATE_QUADWORD_BY_BYTES_IMMEDIATE,
      ROTATE_QUADWORD_BY_BITS, ROTATE_QUADWORD_BY_BITS_IMMEDIATE: begin
        rt_value_d = perm_result;
        wrt_en_d   = 1'b1;
      end
      LOAD_QUADWORD_D, STORE_QUADWORD_D: begin
        ls_ea     = ra_input[0:31] + sext_i10_x16(I10_input);
        ls_access = 1'b1;
        ls_store  = (op_input_op_code == STORE_QUADWORD_D);
      end
      LOAD_QUADWORD_X, STORE_QUADWORD_X: begin
        ls_ea     = ra_input[0:31] + rb_input[0:31];
        ls_access = 1'b1;
        ls_store  = (op_input_op_code == STORE_QUADWORD_X);
      end
      LOAD_QUADWORD_A, STORE_QUADWORD_A: begin
        ls_ea     = sext_i16_x4(I16_input);
        ls_access = 1'b1;
        ls_store  = (op_input_op_code == STORE_QUADWORD_A);
      end
      BRANCH_RELATIVE: pc_d = rel_target;
      BRANCH_ABSOLUTE: pc_d = sext_i16_x4(I16_input) & PC_MASK;
      BRANCH_RELATIVE_AND_SET_LINK: begin
        pc_d       = rel_target;
        rt_value_d = {PC_input + 32'd4, 96'd0};
        wrt_en_d   = 1'b1;
      end
      BRANCH_INDIRECT:         pc_d = ra_input[0:31] & PC_MASK;
      BRANCH_IF_NOT_ZERO_WORD: if (rc_input[0:31] != 32'd0) pc_d = rel_target;
      BRANCH_IF_ZERO_WORD:     if (rc_input[0:31] == 32'd0) pc_d = rel_target;
      default: ;
    endcase
    if (ls_access && !ls_store) begin
      rt_value_d = LS_data_input;
      wrt_en_d   = 1'b1;
    end
  end

  // The LS port is gated during reset so a store sitting on the opcode lines cannot commit.
  always_comb begin
    LS_address_output = (ls_access && !reset) ? (ls_ea[14:0] & LS_ADDR_MASK) : 15'd0;
    LS_data_output    = (ls_store && !reset) ? rc_input : '0;
    LS_wrt_en         = ls_store && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= 32'd0;
      rt_value_q   <= '0;
      rt_address_q <= 7'd0;
      wrt_en_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      rt_value_q   <= rt_value_d;
      rt_address_q <= rt_address_d;
      wrt_en_q     <= wrt_en_d;
    end
  end

  assign PC_output         = pc_q;
  assign rt_value_output   = rt_value_q;
  assign rt_address_output = rt_address_q;
  assign wrt_en_output     = wrt_en_q;

endmodule

// File: tb/tb_odd_pipe.sv
// Directed plus random bench for odd_pipe against an arithmetic reference model with an LS memory.
module tb_odd_pipe;
  import descriptions::*;

  typedef struct packed {
    logic [31:0]  pc;
    logic [0:127] rt;
    logic [6:0]   rta;
    logic         wen;
    logic [14:0]  lsa;
    logic [0:127] lsd;
    logic         lswe;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  opcode        op;
  logic [0:6]   i7;
  logic [0:9]   i10;
  logic [0:15]  i16;
  logic [0:17]  i18;
  logic [0:127] ra, rb, rc;
  logic [6:0]   rta;
  logic [31:0]  pc_in;

  logic [31:0]  pc_out;
  logic [0:127] rt_out, ls_rd, lsd_out;
  logic [6:0]   rta_out;
  logic         wen_out, lswe_out;
  logic [0:14]  lsa_out;

  logic [0:127] ls_mem [0:2047];
  opcode        op_list [23];
  int           total = 0;
  int           bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (lswe_out) ls_mem[lsa_out[0:10]] <= lsd_out;
  assign ls_rd = ls_mem[lsa_out[0:10]];

  odd_pipe dut (
    .clock(clock), .reset(reset), .op_input_op_code(op),
    .I7_input(i7), .I10_input(i10), .I16_input(i16), .I18_input(i18),
    .ra_input(ra), .rb_input(rb), .rc_input(rc), .rt_address_input(rta),
    .PC_input(pc_in), .PC_output(pc_out), .rt_value_output(rt_out),
    .rt_address_output(rta_out), .wrt_en_output(wen_out),
    .LS_address_output(lsa_out), .LS_data_input(ls_rd),
    .LS_data_output(lsd_out), .LS_wrt_en(lswe_out)
  );

  task automatic check(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int t10, t16, n;
    logic [31:0] s10, s16, rel, ea;
    logic [0:255] dbl, sh;
    t10 = $signed(i10);
    t16 = $signed(i16);
    s10 = t10 * 16;
    s16 = t16 * 4;
    rel = (pc_in + s16) & 32'h7FFC;
    dbl = {ra, ra};
    sh  = {ra, 128'd0};
    ea  = 32'd0;
    e = '0;
    e.pc  = pc_in + 32'd4;
    e.rta = rta;
    if (reset) return '0;
    case (op)
      SHIFT_LEFT_QUADWORD_BY_BITS:           begin e.rt = ra * (128'd1 << rb[29:31]); e.wen = 1; end
      SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE: begin e.rt = ra * (128'd1 << i7[4:6]); e.wen = 1; end
      SHIFT_LEFT_QUADWORD_BY_BYTES: begin
        n = int'(rb[27:31]); e.rt = (n >= 16) ? 128'd0 : sh[8*n +: 128]; e.wen = 1;
      end
      SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE: begin
        n = int'(i7[2:6]); e.rt = (n >= 16) ? 128'd0 : sh[8*n +: 128]; e.wen = 1;
      end
      ROTATE_QUADWORD_BY_BYTES:           begin n = int'(rb[28:31]); e.rt = dbl[8*n +: 128]; e.wen = 1; end
      ROTATE_QUADWORD_BY_BYTES_IMMEDIATE: begin n = int'(i7[3:6]); e.rt = dbl[8*n +: 128]; e.wen = 1; end
      ROTATE_QUADWORD_BY_BITS:            begin n = int'(rb[29:31]); e.rt = dbl[n +: 128]; e.wen = 1; end
      ROTATE_QUADWORD_BY_BITS_IMMEDIATE:  begin n = int'(i7[4:6]); e.rt = dbl[n +: 128]; e.wen = 1; end
      LOAD_QUADWORD_D, STORE_QUADWORD_D: ea = ra[0:31] + s10;
      LOAD_QUADWORD_X, STORE_QUADWORD_X: ea = ra[0:31] + rb[0:31];
      LOAD_QUADWORD_A, STORE_QUADWORD_A: ea = s16;
      BRANCH_RELATIVE: e.pc = rel;
      BRANCH_ABSOLUTE: e.pc = s16 & 32'h7FFC;
      BRANCH_RELATIVE_AND_SET_LINK: begin e.pc = rel; e.rt = {pc_in + 32'd4, 96'd0}; e.wen = 1; end
      BRANCH_INDIRECT: e.pc = ra[0:31] & 32'h7FFC;
      BRANCH_IF_NOT_ZERO_WORD: if (rc[0:31] != 0) e.pc = rel;
      BRANCH_IF_ZERO_WORD:     if (rc[0:31] == 0) e.pc = rel;
      default: ;
    endcase
    if (op inside {LOAD_QUADWORD_D, LOAD_QUADWORD_X, LOAD_QUADWORD_A}) begin
      e.lsa = ea[14:0] & 15'h7FF0;
      e.rt  = ls_mem[e.lsa[14:4]];
      e.wen = 1;
    end
    if (op inside {STORE_QUADWORD_D, STORE_QUADWORD_X, STORE_QUADWORD_A}) begin
      e.lsa = ea[14:0] & 15'h7FF0;
      e.lsd = rc;
      e.lswe = 1;
    end
    return e;
  endfunction

  // Inputs are driven just after a falling edge; LS outputs are checked before the
  // rising edge, registered outputs 1 time unit after it.
  task automatic run_step(input string name);
    exp_t e;
    #1;
    e = model();
    check({name, ".ls_addr"}, 128'(lsa_out), 128'(e.lsa));
    check({name, ".ls_data"}, lsd_out, e.lsd);
    check({name, ".ls_we"}, 128'(lswe_out), 128'(e.lswe));
    @(posedge clock);
    #1;
    check({name, ".pc"}, 128'(pc_out), 128'(e.pc));
    check({name, ".rt"}, rt_out, e.rt);
    check({name, ".rt_addr"}, 128'(rta_out), 128'(e.rta));
    check({name, ".wen"}, 128'(wen_out), 128'(e.wen));
    @(negedge clock);
  endtask

  task automatic randomize_operands();
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    rc = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) rc[0:31] = 32'd0;
    i7 = 7'($urandom); i10 = 10'($urandom); i16 = 16'($urandom); i18 = 18'($urandom);
    rta = 7'($urandom); pc_in = $urandom;
  endtask

  initial begin
    op_list = '{NO_OPERATION_LOAD, SHIFT_LEFT_QUADWORD_BY_BITS, SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE,
                SHIFT_LEFT_QUADWORD_BY_BYTES, SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE,
                ROTATE_QUADWORD_BY_BYTES, ROTATE_QUADWORD_BY_BYTES_IMMEDIATE,
                ROTATE_QUADWORD_BY_BITS, ROTATE_QUADWORD_BY_BITS_IMMEDIATE,
                LOAD_QUADWORD_D, LOAD_QUADWORD_X, LOAD_QUADWORD_A,
                STORE_QUADWORD_D, STORE_QUADWORD_X, STORE_QUADWORD_A,
                BRANCH_RELATIVE, BRANCH_ABSOLUTE, BRANCH_RELATIVE_AND_SET_LINK, BRANCH_INDIRECT,
                BRANCH_IF_NOT_ZERO_WORD, BRANCH_IF_ZERO_WORD, ADD_WORD, opcode'(7'h7F)};
    for (int i = 0; i < 2048; i++) ls_mem[i] = '0;
    reset = 1'b1; op = STORE_QUADWORD_A;
    ra = '0; rb = '0; rc = 128'hAB; i7 = '0; i10 = '0; i16 = 16'h0005; i18 = '0;
    rta = 7'd9; pc_in = 32'h100;
    @(negedge clock);
    run_step("rst_store");
    check("rst_store.ls_we_zero", 128'(lswe_out), 128'd0);
    check("rst_store.pc_zero", 128'(pc_out), 128'd0);

    reset = 1'b0;
    op = SHIFT_LEFT_QUADWORD_BY_BITS; ra = 128'd20; rb = {32'd10, 96'd0}; rta = 7'd3;
    run_step("shlqbi");
    check("plan.shlqbi_rt", rt_out, 128'd80);
    check("plan.shlqbi_pc", 128'(pc_out), 128'h104);

    op = SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE; ra = 128'd15; i7 = 7'd5;
    run_step("shlqbii");
    check("plan.shlqbii_rt", rt_out, 128'd480);

    op = SHIFT_LEFT_QUADWORD_BY_BYTES; ra = {4{32'hDEADBEEF}}; rb = {32'd16, 96'd0};
    run_step("shlqby16");
    check("plan.shlqby16_rt", rt_out, 128'd0);

    op = STORE_QUADWORD_D; ra = {32'h100, 96'd0}; i10 = 10'd2; rc = 128'hAB;
    run_step("stqd");
    check("plan.stqd_addr", 128'(lsa_out), 128'h120);

    op = LOAD_QUADWORD_D; rc = 128'd0;
    run_step("lqd");
    check("plan.lqd_rt", rt_out, 128'hAB);

    op = BRANCH_IF_NOT_ZERO_WORD; pc_in = 32'h40; i16 = 16'd4; rc = 128'd0;
    run_step("brnz_nt");
    check("plan.brnz_nt_pc", 128'(pc_out), 128'h44);
    rc = {32'd1, 96'd0};
    run_step("brnz_t");
    check("plan.brnz_t_pc", 128'(pc_out), 128'h50);

    op = BRANCH_RELATIVE_AND_SET_LINK; pc_in = 32'h10; i16 = 16'hFFFE;
    run_step("brsl");
    check("plan.brsl_pc", 128'(pc_out), 128'h08);
    check("plan.brsl_rt", rt_out, {32'h14, 96'd0});

    op = opcode'(7'h7F); ra = '1;
    run_step("unlisted");

    op = SHIFT_LEFT_QUADWORD_BY_BITS; reset = 1'b1;
    run_step("mid_reset");
    reset = 1'b0;

    for (int k = 0; k < 400; k++) begin
      randomize_operands();
      op = op_list[$urandom_range(0, 22)];
      reset = ($urandom_range(0, 49) == 0);
      run_step($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
